// File: rtl/counter_sched.sv
// Round-robin owner of a shared interval counter: grants one requester at a time,
// counts its requested number of cycles, pulses its done flag, then re-arbitrates.
module counter_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len,
    input  logic                  abort,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [WIDTH-1:0]      count,
    output logic                  cnt_enable,
    output logic [NREQ-1:0]       done
);

    localparam int unsigned N  = NREQ;
    localparam int          PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_n;
    logic [PW-1:0]     owner, owner_n, ptr, ptr_n;
    logic [PW-1:0]     owner_next, win, idx_p;
    logic [WIDTH-1:0]  limit, limit_n, count_q, count_n, win_len;
    logic [WIDTH-1:0]  len_a [NREQ];
    logic              found;
    int unsigned       idx;

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            len_a[i] = len[i*WIDTH +: WIDTH];
        end
    end

    // First set request at or above the pointer, wrapping to the bottom.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        win_len = '0;
        idx     = 0;
        idx_p   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx   = (32'(ptr) + k) % N;
            idx_p = PW'(idx);
            if (!found && req[idx_p]) begin
                found   = 1'b1;
                win     = idx_p;
                win_len = len_a[idx_p];
            end
        end
    end

    assign owner_next = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
    assign count      = count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= '0;
            ptr     <= '0;
            limit   <= '0;
            count_q <= '0;
        end else begin
            state   <= state_n;
            owner   <= owner_n;
            ptr     <= ptr_n;
            limit   <= limit_n;
            count_q <= count_n;
        end
    end

    always_comb begin
        state_n    = state;
        owner_n    = owner;
        ptr_n      = ptr;
        limit_n    = limit;
        count_n    = count_q;
        grant      = '0;
        done       = '0;
        busy       = 1'b0;
        cnt_enable = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    owner_n = win;
                    limit_n = win_len;
                    count_n = '0;
                    state_n = (win_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                busy         = 1'b1;
                cnt_enable   = 1'b1;
                grant[owner] = 1'b1;
                if (abort) begin
                    state_n = IDLE;
                    count_n = '0;
                    ptr_n   = owner_next;
                end else if (count_q == limit - WIDTH'(1)) begin
                    state_n = DONE;
                    count_n = '0;
                end else begin
                    count_n = count_q + WIDTH'(1);
                end
            end
            DONE: begin
                busy         = 1'b1;
                grant[owner] = 1'b1;
                done[owner]  = 1'b1;
                state_n      = IDLE;
                ptr_n        = owner_next;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/counter_sched.md
Name: counter_sched

Overview:
Round-robin scheduler that time-shares one free-running interval counter between NREQ requesters. Each requester asks for an interval of len clock cycles. The block grants one requester at a time and runs the counter for exactly that many cycles. It then pulses that requester's done flag and re-arbitrates. It sits between the requester blocks and the counter datapath, driving the counter's enable and reset and exposing the live count.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, counter and interval-length width in bits

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
req  input  NREQ  level request per requester
len  input  NREQ*WIDTH  interval length per requester; slice i = len[i*WIDTH +: WIDTH]
abort  input  1  cancel the interval currently running
grant  output  NREQ  one-hot owner of the counter; all zero when idle
busy  output  1  high in RUN or DONE
count  output  WIDTH  current count of the granted interval; 0 when not running
cnt_enable  output  1  counter enable (high in RUN)
done  output  NREQ  one-cycle pulse to the owner on normal completion

Behaviour:
- Reset (async, any time, including mid-RUN): state=IDLE, grant=0, done=0, busy=0, count=0, cnt_enable=0, priority pointer=0. No done pulse is issued for an interrupted interval.
- States: IDLE, RUN, DONE.
- IDLE: if any req bit is high, pick the first set bit searching from the pointer upward, with wrap-around.
  - Winner i: latch limit=len slice i; grant[i]=1; count=0.
  - Next state is RUN if limit!=0, else DONE.
  - If no req bit is high, stay in IDLE.
  - Arbitration latency: grant is asserted on the first rising edge after req is seen high in IDLE.
- RUN: cnt_enable=1; count increments by 1 each edge.
  - RUN lasts exactly limit cycles; count shows 0, 1, ..., limit-1.
  - On the edge where count==limit-1: go to DONE, count=0.
  - len=2^WIDTH-1 is the maximum interval. count never wraps.
- DONE (one cycle): grant held; done[i]=1; cnt_enable=0.
  - Next edge: go to IDLE, grant=0, pointer=(i+1) mod NREQ.
- abort in RUN: next edge goes to IDLE, grant=0, count=0, no done pulse, pointer=(i+1) mod NREQ. abort is ignored in IDLE and DONE.
- len is sampled only at grant. Changes to len or to the owner's req during RUN have no effect.
- Dropping req while granted does not shorten the interval. Only abort does.
- An owner that still holds req after DONE competes again. It has the lowest priority on that arbitration.
- Simultaneous requests: strictly round-robin from the pointer. No requester is starved.
- grant is always one-hot or zero. done is a subset of grant.
- Minimum turnaround between back-to-back grants: limit+2 cycles (RUN + DONE + IDLE).

Test Plan:
- Reset, then req=0001, len0=5 → grant=0001 on the next edge; count 0,1,2,3,4 over 5 cycles; done=0001 for 1 cycle; grant=0 the following cycle.
- req=1111 held continuously, all len=2 → grants cycle 0001, 0010, 0100, 1000, 0001; each done pulses once per 4-cycle slot.
- req=0010, len1=0 → grant=0010 and done=0010 in the same single cycle; cnt_enable never high.
- req=0100, len2=10, abort asserted when count=3 → next edge grant=0, count=0, no done; pointer moves to 3, so a later req=1001 grants 1000 first.
- Async reset asserted mid-RUN at count=6 → grant, busy, count, cnt_enable go to 0 without waiting for a clock edge; no done after reset is released.
- During RUN of requester 0 with len0=4, change len0 to 9 and drop req0 → interval still ends after exactly 4 count cycles with done=0001.
